// File: rtl/ssm_pkg.sv
// Shared parameters and types for the substream word dispatcher.
package ssm_pkg;
  localparam int NUM_SSM   = 4;
  localparam int WORD_W    = 128;
  localparam int DEPTH     = 2;
  localparam int SSM_IDX_W = $clog2(NUM_SSM);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;
endpackage

// File: rtl/ssm_word_fifo.sv
// Per-SSM prefetch FIFO: show-ahead head, flush, zero head when empty.
module ssm_word_fifo #(
  parameter int WORD_W = 128,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [WORD_W-1:0] head,
  output logic              avail
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     wpos;
  logic              pop;
  logic              push;

  assign pop   = rd_en && (cnt != '0);
  assign push  = wr_en && ((cnt != CW'(DEPTH)) || pop);
  assign wpos  = cnt - CW'(pop);
  assign avail = (cnt != '0);
  assign head  = avail ? mem[0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Entry 0 is always the head; a pop shifts the rest down.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!flush) begin
        if (push && (wpos == CW'(i)))
          mem[i] <= wr_data;
        else if (pop && (i < DEPTH - 1))
          mem[i] <= mem[(i + 1) % DEPTH];
      end
    end
  end
endmodule

// File: rtl/ssm_word_dispatch.sv
// Routes shared bitstream words into per-SSM prefetch FIFOs
// in the order the parsers consumed them.
module ssm_word_dispatch
  import ssm_pkg::*;
#(
  parameter int NUM_SSM = ssm_pkg::NUM_SSM,
  parameter int WORD_W  = ssm_pkg::WORD_W,
  parameter int DEPTH   = ssm_pkg::DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic [WORD_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_SSM-1:0]        ssm_rd_en,
  output logic [NUM_SSM*WORD_W-1:0] ssm_data,
  output logic [NUM_SSM-1:0]        ssm_avail,
  output logic                      start_dec,
  output logic                      underflow
);
  localparam int TOTAL = NUM_SSM * DEPTH;
  localparam int CW    = $clog2(TOTAL) + 1;
  localparam int QW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int IW    = (NUM_SSM > 1) ? $clog2(NUM_SSM) : 1;

  state_t             state, state_nxt;
  logic [CW-1:0]      prime_cnt;
  logic [CW-1:0]      q_rd, q_wr, q_cnt;
  logic [IW-1:0]      q [TOTAL];
  logic [NUM_SSM-1:0] pop_ok, wr_vec;
  logic [CW-1:0]      rank [NUM_SSM];
  logic [CW-1:0]      enq_cnt;
  logic [IW-1:0]      tgt;
  logic               acc, deq;

  function automatic logic [CW-1:0] wrap(input logic [CW:0] a);
    if (a >= (CW+1)'(TOTAL))
      return CW'(a - (CW+1)'(TOTAL));
    return CW'(a);
  endfunction

  assign acc = in_valid && in_ready && !frame_start;
  assign deq = acc && (state == RUN);
  assign pop_ok = (state == RUN && !frame_start) ?
                  (ssm_rd_en & ssm_avail) : '0;
  assign tgt = (state == PRIME) ?
               IW'(prime_cnt % CW'(NUM_SSM)) : q[QW'(q_rd)];
  assign wr_vec = acc ? (NUM_SSM'(1) << tgt) : '0;

  // Same-cycle pops get consecutive queue slots, lowest index first.
  always_comb begin
    enq_cnt = '0;
    for (int i = 0; i < NUM_SSM; i++) begin
      rank[i] = enq_cnt;
      enq_cnt = enq_cnt + CW'(pop_ok[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      frame_start: state_nxt = PRIME;
      (state == PRIME) && acc &&
      (prime_cnt == CW'(TOTAL - 1)): state_nxt = RUN;
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    start_dec = 1'b0;
    unique case (state)
      PRIME: in_ready = 1'b1;
      RUN: begin
        in_ready  = (q_cnt != '0);
        start_dec = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prime_cnt <= '0;
      q_rd      <= '0;
      q_wr      <= '0;
      q_cnt     <= '0;
      underflow <= 1'b0;
    end else if (frame_start) begin
      prime_cnt <= '0;
      q_rd      <= '0;
      q_wr      <= '0;
      q_cnt     <= '0;
      underflow <= 1'b0;
    end else begin
      if (acc && state == PRIME)
        prime_cnt <= prime_cnt + CW'(1);
      if (deq)
        q_rd <= wrap({1'b0, q_rd} + (CW+1)'(1));
      q_wr  <= wrap({1'b0, q_wr} + {1'b0, enq_cnt});
      q_cnt <= q_cnt + enq_cnt - CW'(deq);
      if (state == RUN && |(ssm_rd_en & ~ssm_avail))
        underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SSM; i++) begin
      if (pop_ok[i])
        q[QW'(wrap({1'b0, q_wr} + {1'b0, rank[i]}))] <= IW'(i);
    end
  end

  for (genvar g = 0; g < NUM_SSM; g++) begin : g_fifo
    ssm_word_fifo #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (frame_start),
      .wr_en   (wr_vec[g]),
      .wr_data (in_data),
      .rd_en   (pop_ok[g]),
      .head    (ssm_data[g*WORD_W +: WORD_W]),
      .avail   (ssm_avail[g])
    );
  end
endmodule

// File: tb/tb_ssm_word_dispatch.sv
// Directed bench for ssm_word_dispatch.
module tb_ssm_word_dispatch;
  localparam int N = 4;
  localparam int W = 128;

  logic           clk = 1'b0;
  logic           rst;
  logic           frame_start;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   ssm_rd_en;
  logic [N*W-1:0] ssm_data;
  logic [N-1:0]   ssm_avail;
  logic           start_dec;
  logic           underflow;

  int nvec = 0;
  int nerr = 0;

  ssm_word_dispatch dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ssm_rd_en   (ssm_rd_en),
    .ssm_data    (ssm_data),
    .ssm_avail   (ssm_avail),
    .start_dec   (start_dec),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] word(input int n);
    logic [31:0] v;
    v = n;
    return {16'hC0DE, 80'h0, v};
  endfunction

  function automatic logic [W-1:0] sl(input int i);
    return ssm_data[i*W +: W];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    frame_start = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    ssm_rd_en   = '0;
  endtask

  task automatic pop(input logic [N-1:0] m);
    ssm_rd_en = m;
    step();
    ssm_rd_en = '0;
  endtask

  task automatic feed(input int n);
    in_data  = word(n);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    nvec++;
    if (in_ready !== 1'b0 || start_dec !== 1'b0 || underflow !== 1'b0) begin
      nerr++;
      $display("FAIL reset_ctl got rdy=%b sd=%b uf=%b exp 0 0 0",
               in_ready, start_dec, underflow);
    end
    nvec++;
    if (ssm_avail !== 4'h0 || ssm_data !== '0) begin
      nerr++;
      $display("FAIL reset_data got avail=%h exp 0", ssm_avail);
    end
    rst = 1'b0;
    pop(4'hF);
    nvec++;
    if (underflow !== 1'b0 || in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL idle_ignore got uf=%b rdy=%b exp 0 0", underflow, in_ready);
    end
  endtask

  task automatic test_prime();
    frame_start = 1'b1;
    in_valid    = 1'b1;
    in_data     = word(99);
    step();
    idle();
    nvec++;
    if (in_ready !== 1'b1 || ssm_avail !== 4'h0) begin
      nerr++;
      $display("FAIL fs_no_accept got rdy=%b avail=%h exp 1 0", in_ready, ssm_avail);
    end
    for (int n = 0; n < 7; n++) feed(n);
    nvec++;
    if (start_dec !== 1'b0) begin
      nerr++;
      $display("FAIL prime_sd_early got %b exp 0", start_dec);
    end
    feed(7);
    nvec++;
    if (start_dec !== 1'b1 || in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL prime_done got sd=%b rdy=%b exp 1 0", start_dec, in_ready);
    end
    for (int i = 0; i < N; i++) begin
      nvec++;
      if (sl(i) !== word(i) || ssm_avail[i] !== 1'b1) begin
        nerr++;
        $display("FAIL prime_head%0d got %h exp %h", i, sl(i), word(i));
      end
    end
  endtask

  task automatic test_ordered_refill();
    pop(4'b0100);
    nvec++;
    if (sl(2) !== word(6) || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL refill_pop2 got %h rdy=%b exp %h 1", sl(2), in_ready, word(6));
    end
    step();
    pop(4'b0001);
    nvec++;
    if (sl(0) !== word(4)) begin
      nerr++;
      $display("FAIL refill_pop0 got %h exp %h", sl(0), word(4));
    end
    feed(8);
    feed(9);
    nvec++;
    if (in_ready !== 1'b0 || sl(2) !== word(6)) begin
      nerr++;
      $display("FAIL refill_fill got rdy=%b s2=%h exp 0 %h", in_ready, sl(2), word(6));
    end
    pop(4'b0100);
    pop(4'b0001);
    nvec++;
    if (sl(2) !== word(8) || sl(0) !== word(9)) begin
      nerr++;
      $display("FAIL refill_route got s2=%h s0=%h exp %h %h",
               sl(2), sl(0), word(8), word(9));
    end
    feed(10);
    feed(11);
  endtask

  task automatic test_simul_pops();
    pop(4'b1011);
    nvec++;
    if (sl(0) !== word(11) || sl(1) !== word(5) || sl(3) !== word(7)) begin
      nerr++;
      $display("FAIL simul_heads got s0=%h s1=%h s3=%h", sl(0), sl(1), sl(3));
    end
    feed(12);
    feed(13);
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL simul_q_mid got rdy=%b exp 1", in_ready);
    end
    feed(14);
    nvec++;
    if (in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL simul_q_empty got rdy=%b exp 0", in_ready);
    end
    pop(4'b1011);
    nvec++;
    if (sl(0) !== word(12) || sl(1) !== word(13) || sl(3) !== word(14)) begin
      nerr++;
      $display("FAIL simul_route got s0=%h s1=%h s3=%h", sl(0), sl(1), sl(3));
    end
  endtask

  task automatic test_pop_refill();
    feed(15);
    ssm_rd_en = 4'b0010;
    feed(16);
    ssm_rd_en = '0;
    nvec++;
    if (sl(1) !== word(16) || ssm_avail[1] !== 1'b1) begin
      nerr++;
      $display("FAIL poprefill_head got %h exp %h", sl(1), word(16));
    end
    feed(17);
    feed(18);
    nvec++;
    if (in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL poprefill_q got rdy=%b exp 0", in_ready);
    end
    pop(4'b0010);
    nvec++;
    if (sl(1) !== word(18)) begin
      nerr++;
      $display("FAIL poprefill_depth got %h exp %h", sl(1), word(18));
    end
    feed(19);
  endtask

  task automatic test_underflow();
    pop(4'b0100);
    nvec++;
    if (sl(2) !== word(10)) begin
      nerr++;
      $display("FAIL uf_drain1 got %h exp %h", sl(2), word(10));
    end
    pop(4'b0100);
    nvec++;
    if (sl(2) !== '0 || ssm_avail[2] !== 1'b0 || underflow !== 1'b0) begin
      nerr++;
      $display("FAIL uf_empty got s2=%h av=%b uf=%b exp 0 0 0",
               sl(2), ssm_avail[2], underflow);
    end
    pop(4'b0100);
    nvec++;
    if (underflow !== 1'b1 || sl(2) !== '0 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL uf_flag got uf=%b rdy=%b exp 1 1", underflow, in_ready);
    end
    feed(20);
    feed(21);
    nvec++;
    if (in_ready !== 1'b0 || sl(2) !== word(20) || underflow !== 1'b1) begin
      nerr++;
      $display("FAIL uf_queue got rdy=%b s2=%h uf=%b exp 0 %h 1",
               in_ready, sl(2), underflow, word(20));
    end
  endtask

  task automatic test_restart();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    nvec++;
    if (ssm_avail !== 4'h0 || start_dec !== 1'b0 || underflow !== 1'b0 ||
        in_ready !== 1'b1 || ssm_data !== '0) begin
      nerr++;
      $display("FAIL restart_flush got av=%h sd=%b uf=%b rdy=%b exp 0 0 0 1",
               ssm_avail, start_dec, underflow, in_ready);
    end
    for (int n = 30; n < 34; n++) feed(n);
    for (int i = 0; i < N; i++) begin
      nvec++;
      if (sl(i) !== word(30 + i)) begin
        nerr++;
        $display("FAIL reprime_head%0d got %h exp %h", i, sl(i), word(30 + i));
      end
    end
    nvec++;
    if (start_dec !== 1'b0 || ssm_avail !== 4'hF) begin
      nerr++;
      $display("FAIL reprime_mid got sd=%b av=%h exp 0 f", start_dec, ssm_avail);
    end
    #2;
    rst = 1'b1;
    #1;
    nvec++;
    if (ssm_avail !== 4'h0 || ssm_data !== '0 || in_ready !== 1'b0 ||
        start_dec !== 1'b0 || underflow !== 1'b0) begin
      nerr++;
      $display("FAIL async_rst got av=%h rdy=%b sd=%b exp 0 0 0",
               ssm_avail, in_ready, start_dec);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_prime();
    test_ordered_refill();
    test_simul_pops();
    test_pop_refill();
    test_underflow();
    test_restart();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
